// File: rtl/mul_arbiter_if.sv
// Bundle between mul_arbiter and its requesters plus the shared multiplier engine.
// Handshake: a requester holds req_valid[k] with req_x stable until req_ready[k] pulses; resp_valid pulses once per run.
interface mul_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [15*N_REQ-1:0] req_x;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ-1:0]    resp_valid;
   logic [35:0]         resp_codes;
   logic                resp_early;
   logic                busy;
   logic [14:0]         eng_x;
   logic                eng_valid;
   logic                eng_mul_valid;
   logic [35:0]         eng_codes;

   modport slave (
      input  req_valid, req_x, eng_mul_valid, eng_codes,
      output req_ready, resp_valid, resp_codes, resp_early, busy, eng_x, eng_valid
   );

   modport master (
      output req_valid, req_x, eng_mul_valid, eng_codes,
      input  req_ready, resp_valid, resp_codes, resp_early, busy, eng_x, eng_valid
   );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin front end sharing one factor-decomposition engine between N_REQ requesters.
// Each run: grant, issue, wait for done or timeout, respond; all outputs registered.
module mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 32,
   parameter int CW      = 5
) (
   input  logic          clk,
   input  logic          rst,
   mul_arbiter_if.slave  bus,
   output logic [1:0]    dbg_state
);
   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     gnt_q, gnt_d, rr_q, rr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [14:0]       ex_q, ex_d;
   logic [35:0]       codes_q, codes_d;
   logic              early_q, early_d;
   logic              busy_q, busy_d;
   logic              ev_q, ev_d;
   logic [N_REQ-1:0]  ready_q, ready_d;
   logic [N_REQ-1:0]  rv_q, rv_d;

   logic [IW-1:0]     pick;
   logic              found;
   logic [IW:0]       sum;
   logic [14:0]       ex_sel;

   // Search starts one past the last grant and wraps, so the last winner has lowest priority.
   always_comb begin
      pick   = '0;
      found  = 1'b0;
      sum    = '0;
      ex_sel = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         sum = {1'b0, rr_q} + (IW+1)'(i);
         if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
         if (!found && bus.req_valid[sum[IW-1:0]]) begin
            pick  = sum[IW-1:0];
            found = 1'b1;
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (pick == IW'(k)) ex_sel = bus.req_x[k*15 +: 15];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      ex_d    = ex_q;
      codes_d = codes_q;
      early_d = early_q;
      ready_d = '0;
      rv_d    = '0;
      ev_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d        = pick;
               rr_d         = pick;
               ex_d         = ex_sel;
               ready_d[pick] = 1'b1;
               ev_d         = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // A done pulse on the last timeout cycle still counts as a normal completion.
            if (bus.eng_mul_valid) begin
               codes_d      = bus.eng_codes;
               early_d      = 1'b0;
               rv_d[gnt_q]  = 1'b1;
               state_d      = RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               codes_d      = bus.eng_codes;
               early_d      = 1'b1;
               rv_d[gnt_q]  = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= IW'(N_REQ-1);
         cnt_q   <= '0;
         ex_q    <= '0;
         codes_q <= '0;
         early_q <= 1'b0;
         busy_q  <= 1'b0;
         ev_q    <= 1'b0;
         ready_q <= '0;
         rv_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         ex_q    <= ex_d;
         codes_q <= codes_d;
         early_q <= early_d;
         busy_q  <= busy_d;
         ev_q    <= ev_d;
         ready_q <= ready_d;
         rv_q    <= rv_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = rv_q;
   assign bus.resp_codes = codes_q;
   assign bus.resp_early = early_q;
   assign bus.busy       = busy_q;
   assign bus.eng_x      = ex_q;
   assign bus.eng_valid  = ev_q;
   assign dbg_state      = state_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: cycle-level reference built from run timing rules, directed scenarios, random traffic.
module tb_mul_arbiter;
   localparam int N  = 4;
   localparam int TO = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;

   mul_arbiter_if #(.N_REQ(N)) bus ();

   mul_arbiter #(.N_REQ(N), .TIMEOUT(TO), .CW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- stimulus control ----------------
   int          add_cnt [N];
   int          done_cnt[N];
   logic [14:0] op_tab  [N][8];
   int          eng_mode = 2;
   int          eng_k    = 0;
   logic        fixed_en = 1'b0;
   logic [35:0] fixed_codes = '0;
   int          stray_req  = 0;
   int          stray_done = 0;
   logic [7:0]  exp_q[$];

   // Requesters: keep req_valid up while requests are outstanding, next operand after each accept.
   initial begin
      logic [N-1:0] rdy;
      bus.req_valid = '0;
      bus.req_x     = '0;
      forever begin
         @(negedge clk);
         rdy = bus.req_ready;
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            if (rdy[k]) done_cnt[k]++;
            bus.req_valid[k] = (add_cnt[k] > done_cnt[k]);
            bus.req_x[k*15 +: 15] = op_tab[k][done_cnt[k] % 8];
         end
      end
   end

   // Engine stand-in: done pulse on WAIT cycle index k after a start, random codes every cycle.
   initial begin
      logic [63:0] r;
      int          left;
      logic        armed;
      armed = 1'b0;
      left  = 0;
      bus.eng_mul_valid = 1'b0;
      bus.eng_codes     = '0;
      forever begin
         @(posedge clk); #1;
         r = {$urandom, $urandom};
         bus.eng_mul_valid = 1'b0;
         bus.eng_codes     = r[35:0];
         if (armed) begin
            if (left == 0) begin
               bus.eng_mul_valid = 1'b1;
               if (fixed_en) bus.eng_codes = fixed_codes;
               armed = 1'b0;
            end else left--;
         end
         if (stray_done != stray_req) begin
            bus.eng_mul_valid = 1'b1;
            stray_done = stray_req;
         end
         if (bus.eng_valid) begin
            case (eng_mode)
               0:       begin armed = 1'b1; left = eng_k; end
               1:       armed = 1'b0;
               default: begin armed = 1'b1; left = $urandom_range(0, 40); end
            endcase
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
      for (int i = 1; i <= N; i++) begin
         int j;
         j = (ptr + i) % N;
         if (r[j]) return j;
      end
      return 0;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   logic [N-1:0]     pv_req = '0, cur_req;
   logic [15*N-1:0]  pv_x = '0, cur_x;
   logic             pv_mv = 1'b0, cur_mv;
   logic [35:0]      pv_codes = '0, cur_codes;
   logic             pv_rst = 1'b1, cur_rst;
   logic [35:0]      codes_at[int];

   logic             m_run = 1'b0, m_resp = 1'b0, m_early = 1'b0;
   int               m_gnt = 0, m_rr = N-1, m_start = 0;
   logic [14:0]      m_ex = '0;
   logic [35:0]      m_codes = '0;

   int          ready_count = 0, resp_count = 0;
   int          last_ready_cyc = 0, last_ready_idx = -1, last_resp_cyc = 0, last_resp_idx = -1;
   logic [14:0] last_ready_ex = '0;
   logic [35:0] last_resp_codes = '0;
   logic        last_resp_early = 1'b0;
   logic        obs_busy = 1'b0;
   logic [N-1:0] obs_req = '0;
   int          rise_cyc[N];

   initial begin
      logic [N-1:0] e_ready, e_rv;
      logic         e_ev, e_busy;
      int           g, k;
      forever begin
         @(negedge clk);
         cyc++;
         cur_req = bus.req_valid;  cur_x = bus.req_x;  cur_mv = bus.eng_mul_valid;
         cur_codes = bus.eng_codes;  cur_rst = rst;
         codes_at[cyc] = cur_codes;
         e_ready = '0;  e_rv = '0;  e_ev = 1'b0;  e_busy = 1'b0;
         if (pv_rst) begin
            m_run = 1'b0;  m_resp = 1'b0;  m_rr = N-1;
            m_ex = '0;  m_codes = '0;  m_early = 1'b0;
         end else if (!m_run) begin
            if (pv_req != 0) begin
               g = rr_pick(pv_req, m_rr);
               m_run = 1'b1;  m_gnt = g;  m_rr = g;
               m_ex = pv_x[g*15 +: 15];
               m_start = cyc;
               e_ready[g] = 1'b1;  e_ev = 1'b1;  e_busy = 1'b1;
            end
         end else if (m_resp) begin
            m_run = 1'b0;  m_resp = 1'b0;
         end else begin
            e_busy = 1'b1;
            if (cyc > m_start + 1) begin
               k = cyc - m_start - 2;
               if (pv_mv || k == TO-1) begin
                  e_rv[m_gnt] = 1'b1;
                  m_codes = pv_codes;
                  m_early = !pv_mv;
                  m_resp  = 1'b1;
               end
            end
         end
         chk("req_ready",  64'(bus.req_ready),  64'(e_ready));
         chk("eng_valid",  64'(bus.eng_valid),  64'(e_ev));
         chk("resp_valid", 64'(bus.resp_valid), 64'(e_rv));
         chk("busy",       64'(bus.busy),       64'(e_busy));
         chk("eng_x",      64'(bus.eng_x),      64'(m_ex));
         chk("resp_codes", 64'(bus.resp_codes), 64'(m_codes));
         chk("resp_early", 64'(bus.resp_early), 64'(m_early));

         if (bus.req_ready != 0) begin
            ready_count++;  last_ready_cyc = cyc;
            last_ready_idx = idx_of(bus.req_ready);  last_ready_ex = bus.eng_x;
         end
         if (bus.resp_valid != 0) begin
            resp_count++;  last_resp_cyc = cyc;  last_resp_idx = idx_of(bus.resp_valid);
            last_resp_codes = bus.resp_codes;  last_resp_early = bus.resp_early;
         end
         for (int i = 0; i < N; i++) if (cur_req[i] && !pv_req[i]) rise_cyc[i] = cyc;
         obs_busy = bus.busy;  obs_req = cur_req;
         pv_req = cur_req;  pv_x = cur_x;  pv_mv = cur_mv;  pv_codes = cur_codes;  pv_rst = cur_rst;
      end
   end

   // ---------------- driver tasks ----------------
   int ready_used = 0, resp_used = 0;

   task automatic sync_counts();
      ready_used = ready_count;
      resp_used  = resp_count;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (ready_count == ready_used && n < 300) begin @(posedge clk); n++; end
      if (ready_count == ready_used) begin
         n_checks++;  n_fail++;
         $display("FAIL %s: no req_ready within 300 cycles (cycle %0d)", name, cyc);
      end
      ready_used = ready_count;
   endtask

   task automatic wait_resp(input string name);
      int n;
      n = 0;
      while (resp_count == resp_used && n < 300) begin @(posedge clk); n++; end
      if (resp_count == resp_used) begin
         n_checks++;  n_fail++;
         $display("FAIL %s: no resp_valid within 300 cycles (cycle %0d)", name, cyc);
      end
      resp_used = resp_count;
   endtask

   task automatic wait_idle(input int budget);
      int  n;
      logic pend;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         pend = 1'b0;
         for (int k = 0; k < N; k++) if (add_cnt[k] > done_cnt[k]) pend = 1'b1;
      end while ((pend || obs_busy || obs_req != 0) && n < budget);
      if (pend || obs_busy || obs_req != 0) begin
         n_checks++;  n_fail++;
         $display("FAIL wait_idle: arbiter still active after %0d cycles", budget);
      end
      repeat (2) @(posedge clk);
      sync_counts();
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1 rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int base[N];
      int q, rc;
      for (int k = 0; k < N; k++) begin
         add_cnt[k] = 0;  done_cnt[k] = 0;  rise_cyc[k] = 0;
         for (int j = 0; j < 8; j++) op_tab[k][j] = 15'($urandom);
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy",       64'(bus.busy), 64'h0);
      chk("rst_req_ready",  64'(bus.req_ready), 64'h0);
      chk("rst_resp_codes", 64'(bus.resp_codes), 64'h0);
      chk("rst_eng_x",      64'(bus.eng_x), 64'h0);
      sync_counts();

      // Single request, normal completion after 20 engine cycles
      op_tab[0][0] = 15'h0C00;
      eng_mode = 0;  eng_k = 19;  fixed_en = 1'b1;  fixed_codes = 36'h123456789;
      add_cnt[0]++;
      wait_ready("single_ready");
      chk("single_gnt",     64'(last_ready_idx), 64'd0);
      chk("single_gnt_lat", 64'(last_ready_cyc - rise_cyc[0]), 64'd1);
      chk("single_eng_x",   64'(last_ready_ex), 64'h0C00);
      wait_resp("single_resp");
      chk("single_resp_lat", 64'(last_resp_cyc - last_ready_cyc), 64'd21);
      chk("single_resp_idx", 64'(last_resp_idx), 64'd0);
      chk("single_codes",    64'(last_resp_codes), 64'h123456789);
      chk("single_early",    64'(last_resp_early), 64'd0);
      fixed_en = 1'b0;
      wait_idle(100);

      // Round-robin: all requesters persistent from reset
      do_reset(2);
      sync_counts();
      eng_mode = 2;
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) exp_q.push_back(8'(k));
      for (int k = 0; k < N; k++) begin base[k] = done_cnt[k]; add_cnt[k] += 2; end
      q = -100;
      while (exp_q.size() != 0) begin
         int g;
         g = int'(exp_q.pop_front());
         wait_ready("rr_ready");
         chk("rr_gnt",   64'(last_ready_idx), 64'(g));
         chk("rr_eng_x", 64'(last_ready_ex), 64'(op_tab[g][base[g] % 8]));
         base[g]++;
         if (q >= 0) chk("rr_gap", 64'(last_ready_cyc - q >= 2), 64'd1);
         wait_resp("rr_resp");
         chk("rr_resp_idx", 64'(last_resp_idx), 64'(g));
         q = last_resp_cyc;
      end
      wait_idle(200);

      // Timeout: engine never finishes
      eng_mode = 1;
      add_cnt[2]++;
      wait_ready("to_ready");
      chk("to_gnt", 64'(last_ready_idx), 64'd2);
      wait_resp("to_resp");
      chk("to_resp_lat", 64'(last_resp_cyc - last_ready_cyc), 64'd33);
      chk("to_early",    64'(last_resp_early), 64'd1);
      chk("to_codes",    64'(last_resp_codes), 64'(codes_at[last_resp_cyc-1]));
      wait_idle(100);

      // Done arrives on the final timeout cycle
      eng_mode = 0;  eng_k = 31;
      add_cnt[1]++;
      wait_ready("race_ready");
      wait_resp("race_resp");
      chk("race_resp_lat", 64'(last_resp_cyc - last_ready_cyc), 64'd33);
      chk("race_early",    64'(last_resp_early), 64'd0);
      chk("race_codes",    64'(last_resp_codes), 64'(codes_at[last_resp_cyc-1]));
      wait_idle(100);

      // Reset five cycles into WAIT
      eng_mode = 1;
      add_cnt[0] += 2;
      wait_ready("mrst_ready");
      chk("mrst_gnt0", 64'(last_ready_idx), 64'd0);
      add_cnt[1]++;
      rc = resp_count;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mrst_busy", 64'(bus.busy), 64'd0);
      eng_mode = 0;  eng_k = 3;
      @(posedge clk);
      sync_counts();
      chk("mrst_no_resp", 64'(resp_count), 64'(rc));
      wait_ready("mrst_regrant");
      chk("mrst_regrant", 64'(last_ready_idx), 64'd0);
      wait_idle(200);

      // Stray done pulse in IDLE
      rc = resp_count;
      stray_req++;
      repeat (4) @(posedge clk);
      chk("stray_no_resp", 64'(resp_count), 64'(rc));
      chk("stray_busy",    64'(obs_busy), 64'd0);

      // Request arriving during WAIT waits for the current RESP
      eng_mode = 0;  eng_k = 10;
      add_cnt[3]++;
      wait_ready("busyreq_ready3");
      chk("busyreq_gnt3", 64'(last_ready_idx), 64'd3);
      repeat (3) @(posedge clk);
      add_cnt[2]++;
      wait_resp("busyreq_resp3");
      q = last_resp_cyc;
      wait_ready("busyreq_ready2");
      chk("busyreq_gnt2", 64'(last_ready_idx), 64'd2);
      chk("busyreq_lat2", 64'(last_ready_cyc - q), 64'd2);
      wait_idle(200);

      // Random traffic, latencies, stray pulses and occasional resets
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 99);
         eng_mode = ($urandom_range(0, 9) == 0) ? 1 : 2;
         if (r < 70) add_cnt[$urandom_range(0, N-1)] += $urandom_range(1, 2);
         else if (r < 85) stray_req++;
         else if (r >= 96) do_reset(1);
         if ($urandom_range(0, 3) == 0)
            op_tab[$urandom_range(0, N-1)][$urandom_range(0, 7)] = 15'($urandom);
         repeat ($urandom_range(0, 25)) @(posedge clk);
      end
      wait_idle(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #600000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
